// File: rtl/bitstream_sequencer.sv
// bitstream_sequencer: splits WIDTH-bit bitstream words into DWIDTH-bit bytes, MSB byte first,
// for a downstream Huffman decoder.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - synchronous active-high reset
//   word_data   - incoming word (WIDTH bits)
//   word_valid  - word_data / word_last valid
//   word_last   - word is the final word of its frame
//   word_ready  - sequencer accepts a word this cycle
//   byte_data   - current byte (DWIDTH bits)
//   byte_valid  - byte_data valid
//   byte_last   - final byte of the frame
//   byte_ready  - downstream accepts the byte
//   flush       - abort the current frame, discard any held word
//   busy        - a word is held
//   byte_cnt    - bytes accepted downstream in the current frame (saturating)
module bitstream_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  word_data,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic [DWIDTH-1:0] byte_data,
  output logic              byte_valid,
  output logic              byte_last,
  input  logic              byte_ready,
  input  logic              flush,
  output logic              busy,
  output logic [15:0]       byte_cnt
);

  localparam int unsigned NB = WIDTH / DWIDTH;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] IdxMax = IW'(NB - 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  word_q;
  logic [IW-1:0]     idx_q;
  logic              last_q;
  logic [15:0]       cnt_q;

  logic              emit;
  logic              at_end;
  logic              byte_xfer;
  logic              word_xfer;
  logic [WIDTH-1:0]  shifted;

  always_comb begin
    emit       = (state_q == StEmit);
    at_end     = (idx_q == IdxMax);
    byte_valid = emit & ~flush;
    // Accept the next word in the same cycle the final byte leaves, unless the frame ends here.
    word_ready = ~flush & (~emit | (at_end & byte_ready & ~last_q));
    byte_last  = last_q & at_end;
    busy       = emit;
    byte_cnt   = cnt_q;
    shifted    = word_q << (32'(idx_q) * DWIDTH);
    byte_data  = shifted[WIDTH-1 -: DWIDTH];
    byte_xfer  = byte_valid & byte_ready;
    word_xfer  = word_valid & word_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      idx_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (word_xfer) begin
            word_q  <= word_data;
            last_q  <= word_last;
            idx_q   <= '0;
            state_q <= StEmit;
          end
        end
        StEmit: begin
          if (byte_xfer) begin
            if (!at_end) begin
              idx_q <= idx_q + IW'(1);
            end else if (word_xfer) begin
              word_q <= word_data;
              last_q <= word_last;
              idx_q  <= '0;
            end else begin
              // Clearing idx/last keeps byte_last low while idle.
              state_q <= StIdle;
              idx_q   <= '0;
              last_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (byte_xfer && byte_last) begin
        cnt_q <= '0;
      end else if (byte_xfer && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_sequencer.sv
// Self-checking bench for bitstream_sequencer: table-driven frames through a byte scoreboard,
// plus hand-written sequences for streaming, backpressure, flush, reset and saturation.
module tb_bitstream_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        flush;
  logic        busy;
  logic [15:0] byte_cnt;

  int total = 0;
  int bad   = 0;

  // Expected bytes in order: {last, data}
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;

  bitstream_sequencer #(.WIDTH(32), .DWIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word_ready (word_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .flush      (flush),
    .busy       (busy),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  // Byte monitor: inputs change 1 unit after posedge, so the negedge sees what the next edge will.
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL byte_unexpected got=%h last=%b required=none", byte_data, byte_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({byte_last, byte_data} !== mon_e) begin
          bad++;
          $display("FAIL byte_stream got=%b_%h required=%b_%h",
                   byte_last, byte_data, mon_e[8], mon_e[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  // Present a word, wait (bounded) for acceptance, optionally push its bytes MSB first.
  task automatic send_word(input logic [31:0] w, input logic l, input logic push);
    logic [31:0] t;
    int n;
    word_data  = w;
    word_last  = l;
    word_valid = 1'b1;
    n = 0;
    while (!word_ready && n < 200) begin
      step();
      n++;
    end
    if (!word_ready) begin
      total++;
      bad++;
      $display("FAIL word_accept timeout got=0 required=1");
    end else if (push) begin
      for (int k = 0; k < 4; k++) begin
        t = w << (8 * k);
        exp_q.push_back({l && (k == 3), t[31:24]});
      end
    end
    step();
    word_valid = 1'b0;
    word_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      step();
      n++;
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_idle"}, {31'd0, busy}, 0);
    check({name, "_cnt_clear"}, {16'd0, byte_cnt}, 0);
  endtask

  typedef struct {
    logic [31:0] w;
    logic        last;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'hA1B2C3D4, 1'b1, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    vecs[1] = '{32'h11223344, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44};
    vecs[2] = '{32'h55667788, 1'b1, 8'h55, 8'h66, 8'h77, 8'h88};
    vecs[3] = '{32'hDEADBEEF, 1'b1, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    vecs[4] = '{32'h0F1E2D3C, 1'b0, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    vecs[5] = '{32'h4B5A6978, 1'b1, 8'h4B, 8'h5A, 8'h69, 8'h78};

    rst = 1'b1; word_data = '0; word_valid = 1'b0; word_last = 1'b0;
    byte_ready = 1'b1; flush = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_byte_valid", {31'd0, byte_valid}, 0);
    check("rst_byte_last", {31'd0, byte_last}, 0);
    check("rst_byte_data", {24'd0, byte_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_word_ready", {31'd0, word_ready}, 1);
    check("rst_byte_cnt", {16'd0, byte_cnt}, 0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b0, vecs[i].b0});
      exp_q.push_back({1'b0, vecs[i].b1});
      exp_q.push_back({1'b0, vecs[i].b2});
      exp_q.push_back({vecs[i].last, vecs[i].b3});
      send_word(vecs[i].w, vecs[i].last, 1'b0);
    end
    drain("table");

    // Single word timing: one byte per cycle, byte_last only on D4
    send_word(32'hA1B2C3D4, 1'b1, 1'b1);
    check("single_b0", {23'd0, byte_last, byte_data}, 32'h0A1);
    check("single_busy", {31'd0, busy}, 1);
    step();
    check("single_b1", {23'd0, byte_last, byte_data}, 32'h0B2);
    step();
    check("single_b2", {23'd0, byte_last, byte_data}, 32'h0C3);
    check("single_cnt2", {16'd0, byte_cnt}, 2);
    step();
    check("single_b3", {23'd0, byte_last, byte_data}, 32'h1D4);
    check("single_wr_low_last", {31'd0, word_ready}, 0);
    step();
    check("single_end_busy", {31'd0, busy}, 0);
    check("single_end_cnt", {16'd0, byte_cnt}, 0);
    check("single_end_valid", {31'd0, byte_valid}, 0);

    // Streaming: second word accepted with byte 44, no gap
    send_word(32'h11223344, 1'b0, 1'b1);
    send_word(32'h55667788, 1'b1, 1'b1);
    check("stream_first_b2", {23'd0, byte_valid, byte_data}, 32'h155);
    check("stream_cnt4", {16'd0, byte_cnt}, 4);
    step(); step(); step();
    check("stream_last_byte", {23'd0, byte_last, byte_data}, 32'h188);
    check("stream_cnt_peak", {16'd0, byte_cnt}, 7);
    step();
    check("stream_cnt_clear", {16'd0, byte_cnt}, 0);
    check("stream_idle", {31'd0, busy}, 0);

    // Backpressure at idx=1
    send_word(32'hCAFEBABE, 1'b1, 1'b1);
    step();
    byte_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_hold_data", {23'd0, byte_valid, byte_data}, 32'h1FE);
      check("bp_word_ready", {31'd0, word_ready}, 0);
      check("bp_cnt_hold", {16'd0, byte_cnt}, 1);
      step();
    end
    byte_ready = 1'b1;
    step();
    check("bp_resume", {24'd0, byte_data}, 32'hBA);
    step();
    check("bp_final", {23'd0, byte_last, byte_data}, 32'h1BE);
    drain("bp");

    // Flush at idx=2 together with an offered word and ready downstream
    send_word(32'h01020304, 1'b1, 1'b1);
    step(); step();
    check("flush_pre_byte", {24'd0, byte_data}, 32'h03);
    flush = 1'b1;
    word_data = 32'h99887766; word_last = 1'b1; word_valid = 1'b1;
    #1;
    check("flush_valid_low", {31'd0, byte_valid}, 0);
    check("flush_wready_low", {31'd0, word_ready}, 0);
    step();
    flush = 1'b0; word_valid = 1'b0; word_last = 1'b0;
    exp_q.delete();
    #1;
    check("flush_idle", {31'd0, busy}, 0);
    check("flush_valid_after", {31'd0, byte_valid}, 0);
    check("flush_cnt", {16'd0, byte_cnt}, 0);
    send_word(32'hAABBCCDD, 1'b1, 1'b1);
    check("flush_next_msb", {24'd0, byte_data}, 32'hAA);
    drain("flush");

    // Reset mid-frame with byte_ready high
    send_word(32'h13579BDF, 1'b1, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("mrst_valid", {31'd0, byte_valid}, 0);
    check("mrst_last", {31'd0, byte_last}, 0);
    check("mrst_data", {24'd0, byte_data}, 0);
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_wready", {31'd0, word_ready}, 1);
    check("mrst_cnt", {16'd0, byte_cnt}, 0);

    // Saturation: 16385 non-last words streamed back to back
    for (int i = 0; i < 16385; i++) begin
      send_word({i[15:0], ~i[15:0]}, 1'b0, 1'b1);
    end
    check("sat_reached", {16'd0, byte_cnt}, 32'hFFFF);
    check("sat_valid", {31'd0, byte_valid}, 1);
    step();
    check("sat_hold", {16'd0, byte_cnt}, 32'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    check("sat_flush_cnt", {16'd0, byte_cnt}, 0);
    check("sat_flush_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
